// File: rtl/hazard_sequencer_if.sv
// Interface bundling the hazard sequencer's pipeline-facing inputs, the enable/flush
// controls it drives, and its halt and statistics outputs.
interface hazard_sequencer_if;
  logic [5:0]  id_opcode;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        ex_mem_read;
  logic [4:0]  ex_rt;
  logic        mem_branch_taken;
  logic        dmem_req;
  logic        dmem_ready;
  logic        pc_write;
  logic        ifid_write;
  logic        ifid_flush;
  logic        idex_flush;
  logic        exmem_flush;
  logic        pipe_freeze;
  logic        halted;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  modport master (
    output id_opcode, id_rs, id_rt, ex_mem_read, ex_rt, mem_branch_taken, dmem_req, dmem_ready,
    input  pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, pipe_freeze, halted,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  id_opcode, id_rs, id_rt, ex_mem_read, ex_rt, mem_branch_taken, dmem_req, dmem_ready,
    output pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, pipe_freeze, halted,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_sequencer.sv
// Load-use stall, branch flush, memory freeze and watchdog halt for the 5-stage MIPS core.
// Define HAZARD_STATS_EN to build the saturating stall/flush statistics counters.
module hazard_sequencer #(
  parameter int unsigned WAIT_LIMIT = 16
) (
  input logic               clk,
  input logic               rst_n,
  hazard_sequencer_if.slave bus
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;

  localparam logic [5:0] OP_RTYPE   = 6'b000000;
  localparam logic [5:0] OP_SW      = 6'b101011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [7:0] LAST_WAIT  = 8'(WAIT_LIMIT - 1);

  state_t     state;
  state_t     next_state;
  logic [7:0] wait_cnt;
  logic [7:0] wait_cnt_next;
  logic       halted_q;
  logic       uses_rt;
  logic       load_use;
  logic       mem_busy;
  logic       flush_cycle;
  logic       stall_cycle;

  always_comb begin
    uses_rt = 1'b0;
    case (bus.id_opcode)
      OP_RTYPE, OP_SW, OP_BEQ: uses_rt = 1'b1;
      default:                 uses_rt = 1'b0;
    endcase
  end

  assign load_use = bus.ex_mem_read && (bus.ex_rt != 5'd0) &&
                    ((bus.ex_rt == bus.id_rs) || (uses_rt && (bus.ex_rt == bus.id_rt)));
  assign mem_busy = bus.dmem_req && !bus.dmem_ready;

  // A flush outranks a coincident load-use because the stalled ID instruction is on the wrong path.
  assign flush_cycle = (state != HALT) && !mem_busy && bus.mem_branch_taken;
  assign stall_cycle = (state != HALT) && !mem_busy && !bus.mem_branch_taken && load_use;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= RUN;
      wait_cnt <= 8'd0;
      halted_q <= 1'b0;
    end else begin
      state    <= next_state;
      wait_cnt <= wait_cnt_next;
      halted_q <= halted_q || (next_state == HALT);
    end
  end

  always_comb begin
    next_state    = state;
    wait_cnt_next = wait_cnt;
    case (state)
      RUN, MEM_WAIT: begin
        if (mem_busy) begin
          next_state    = (wait_cnt == LAST_WAIT) ? HALT : MEM_WAIT;
          wait_cnt_next = wait_cnt + 8'd1;
        end else begin
          next_state    = RUN;
          wait_cnt_next = 8'd0;
        end
      end
      HALT:    next_state = HALT;
      default: next_state = RUN;
    endcase
  end

  // A release cycle out of MEM_WAIT decodes exactly like RUN, so only HALT and mem_busy freeze.
  always_comb begin
    bus.pc_write    = 1'b1;
    bus.ifid_write  = 1'b1;
    bus.ifid_flush  = 1'b0;
    bus.idex_flush  = 1'b0;
    bus.exmem_flush = 1'b0;
    bus.pipe_freeze = 1'b0;
    if ((state == HALT) || mem_busy) begin
      bus.pc_write    = 1'b0;
      bus.ifid_write  = 1'b0;
      bus.pipe_freeze = 1'b1;
    end else if (flush_cycle) begin
      bus.ifid_flush  = 1'b1;
      bus.idex_flush  = 1'b1;
      bus.exmem_flush = 1'b1;
    end else if (stall_cycle) begin
      bus.pc_write    = 1'b0;
      bus.ifid_write  = 1'b0;
      bus.idex_flush  = 1'b1;
    end
  end

  assign bus.halted = halted_q;

`ifdef HAZARD_STATS_EN
  logic [15:0] stall_q;
  logic [15:0] flush_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= 16'd0;
      flush_q <= 16'd0;
    end else begin
      if (stall_cycle && (stall_q != 16'hFFFF)) stall_q <= stall_q + 16'd1;
      if (flush_cycle && (flush_q != 16'hFFFF)) flush_q <= flush_q + 16'd1;
    end
  end

  assign bus.stall_cnt = stall_q;
  assign bus.flush_cnt = flush_q;
`else
  assign bus.stall_cnt = 16'd0;
  assign bus.flush_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed self-checking bench for hazard_sequencer, built with WAIT_LIMIT=4.
// Statistics expectations follow HAZARD_STATS_EN when it is defined for the build.
module tb_hazard_sequencer;

  localparam logic [6:0] C_NORM   = 7'b1100000;
  localparam logic [6:0] C_STALL  = 7'b0001000;
  localparam logic [6:0] C_FLUSH  = 7'b1111100;
  localparam logic [6:0] C_FREEZE = 7'b0000010;
  localparam logic [6:0] C_HALT   = 7'b0000011;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  logic [15:0] exp_stall;
  logic [15:0] exp_flush;
  logic [6:0]  ctrl;

  hazard_sequencer_if bus ();

  hazard_sequencer #(.WAIT_LIMIT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign ctrl = {bus.pc_write, bus.ifid_write, bus.ifid_flush, bus.idex_flush,
                 bus.exmem_flush, bus.pipe_freeze, bus.halted};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] stat_exp(input logic [15:0] v);
`ifdef HAZARD_STATS_EN
    return v;
`else
    return 16'd0;
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                               input logic mr, input logic [4:0] exrt, input logic br,
                               input logic req, input logic rdy);
    bus.id_opcode        = op;
    bus.id_rs            = rs;
    bus.id_rt            = rt;
    bus.ex_mem_read      = mr;
    bus.ex_rt            = exrt;
    bus.mem_branch_taken = br;
    bus.dmem_req         = req;
    bus.dmem_ready       = rdy;
  endtask

  task automatic vec(input string tag, input logic [5:0] op, input logic [4:0] rs,
                     input logic [4:0] rt, input logic mr, input logic [4:0] exrt,
                     input logic br, input logic req, input logic rdy, input logic [6:0] exp);
    applyStimulus(op, rs, rt, mr, exrt, br, req, rdy);
    #1;
    checkOutput(tag, {25'd0, ctrl}, {25'd0, exp});
  endtask

  // Advances one edge and mirrors the counter behaviour expected for that cycle.
  task automatic tick(input bit stall, input bit flush);
    @(posedge clk);
    if (!rst_n) begin
      exp_stall = 16'd0;
      exp_flush = 16'd0;
    end else begin
      if (stall && exp_stall != 16'hFFFF) exp_stall = exp_stall + 16'd1;
      if (flush && exp_flush != 16'hFFFF) exp_flush = exp_flush + 16'd1;
    end
    #1;
  endtask

  task automatic checkStats(input string tag);
    checkOutput({tag, " stall_cnt"}, {16'd0, bus.stall_cnt}, {16'd0, stat_exp(exp_stall)});
    checkOutput({tag, " flush_cnt"}, {16'd0, bus.flush_cnt}, {16'd0, stat_exp(exp_flush)});
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    exp_stall = 16'd0;
    exp_flush = 16'd0;
    applyStimulus(6'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    tick(0, 0);
    tick(0, 0);
    rst_n = 1'b1;

    vec("reset ctrl", 6'd0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, C_NORM);
    checkStats("reset");

    // Load-use decode across opcodes
    vec("lu rtype rt", 6'b000000, 5'd1, 5'd5, 1, 5'd5, 0, 0, 0, C_STALL);
    tick(1, 0);
    vec("lu ex_rt zero", 6'b000000, 5'd0, 5'd0, 1, 5'd0, 0, 0, 0, C_NORM);
    tick(0, 0);
    vec("lu no memread", 6'b000000, 5'd5, 5'd5, 0, 5'd5, 0, 0, 0, C_NORM);
    tick(0, 0);
    vec("lu lw rt ignored", 6'b100011, 5'd3, 5'd5, 1, 5'd5, 0, 0, 0, C_NORM);
    tick(0, 0);
    vec("lu lw rs", 6'b100011, 5'd5, 5'd7, 1, 5'd5, 0, 0, 0, C_STALL);
    tick(1, 0);
    vec("lu sw rt", 6'b101011, 5'd2, 5'd9, 1, 5'd9, 0, 0, 0, C_STALL);
    tick(1, 0);
    vec("lu beq rt", 6'b000100, 5'd2, 5'd9, 1, 5'd9, 0, 0, 0, C_STALL);
    tick(1, 0);
    vec("lu addi rt ignored", 6'b001000, 5'd2, 5'd9, 1, 5'd9, 0, 0, 0, C_NORM);
    tick(0, 0);

    // Branch flush beats a coincident load-use
    vec("branch over lu", 6'b000000, 5'd1, 5'd5, 1, 5'd5, 1, 0, 0, C_FLUSH);
    tick(0, 1);
    vec("after branch", 6'd0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, C_NORM);
    checkStats("branch");

    // Three frozen cycles then release; a second burst proves wait_cnt was cleared
    for (int i = 0; i < 3; i++) begin
      vec($sformatf("memwait frz%0d", i), 6'd0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, C_FREEZE);
      tick(0, 0);
    end
    vec("memwait release", 6'd0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 1, C_NORM);
    tick(0, 0);
    for (int i = 0; i < 3; i++) begin
      vec($sformatf("memwait2 frz%0d", i), 6'd0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, C_FREEZE);
      tick(0, 0);
    end
    vec("memwait2 release", 6'd0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, C_NORM);
    tick(0, 0);

    // Branch held in EX/MEM during a freeze flushes on the release cycle
    vec("branch frozen", 6'd0, 5'd0, 5'd0, 0, 5'd0, 1, 1, 0, C_FREEZE);
    tick(0, 0);
    vec("branch release", 6'd0, 5'd0, 5'd0, 0, 5'd0, 1, 1, 1, C_FLUSH);
    tick(0, 1);
    checkStats("branch release");

    // Watchdog: four frozen cycles, halted from the fifth, sticky until reset
    for (int i = 0; i < 4; i++) begin
      vec($sformatf("wdog frz%0d", i), 6'd0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, C_FREEZE);
      tick(0, 0);
    end
    vec("wdog halted", 6'd0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, C_HALT);
    vec("wdog ignores inputs", 6'b000000, 5'd1, 5'd5, 1, 5'd5, 1, 1, 1, C_HALT);
    tick(0, 0);
    vec("wdog still halted", 6'd0, 5'd0, 5'd0, 0, 5'd0, 1, 0, 1, C_HALT);
    checkStats("halt");
    rst_n = 1'b0;
    tick(0, 0);
    rst_n = 1'b1;
    vec("wdog after reset", 6'd0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, C_NORM);
    checkStats("halt reset");

    // Reset during the second MEM_WAIT cycle must clear wait_cnt
    vec("rstwait frz0", 6'd0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, C_FREEZE);
    tick(0, 0);
    vec("rstwait frz1", 6'd0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, C_FREEZE);
    rst_n = 1'b0;
    tick(0, 0);
    rst_n = 1'b1;
    vec("rstwait run", 6'd0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, C_NORM);
    for (int i = 0; i < 3; i++) begin
      vec($sformatf("rstwait post frz%0d", i), 6'd0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, C_FREEZE);
      tick(0, 0);
    end
    vec("rstwait post frz3", 6'd0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, C_FREEZE);
    vec("rstwait release", 6'd0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 1, C_NORM);
    tick(0, 0);
    vec("rstwait not halted", 6'd0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, C_NORM);

    // Counter saturation under a long load-use run
    rst_n = 1'b0;
    tick(0, 0);
    rst_n = 1'b1;
    vec("sat stall", 6'b000000, 5'd4, 5'd0, 1, 5'd4, 0, 0, 0, C_STALL);
`ifdef HAZARD_STATS_EN
    for (int i = 0; i < 65540; i++) tick(1, 0);
    checkOutput("sat stall_cnt", {16'd0, bus.stall_cnt}, 32'h0000FFFF);
`else
    for (int i = 0; i < 20; i++) tick(1, 0);
    checkOutput("stats off stall_cnt", {16'd0, bus.stall_cnt}, 32'd0);
`endif
    checkStats("sat");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
